// File: rtl/decode_stage.sv
// decode_stage: single-entry instruction decode stage with valid/ready
// handshake on both sides.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : upstream handshake, instr[15:0] opcode in [15:12]
//   flush                 : synchronous kill of held and offered instruction
//   out_valid/out_ready   : downstream handshake for the registered bundle
//   rd, rs, rt, ctrl, cond, imm, call, offset : decoded bundle fields
//   halted                : stage sits in HALTED after accepting HLT
//   stall_cnt             : saturating count of load-use bubble cycles
module decode_stage #(
  parameter logic [3:0] LINK_REG    = 4'hF,
  parameter int         HAZARD_EN   = 1,
  parameter int         HALT_STICKY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [6:0]  ctrl,
  output logic [2:0]  cond,
  output logic [8:0]  imm,
  output logic [11:0] call,
  output logic [3:0]  offset,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, BUBBLE, HALTED} state_t;

  state_t      state_reg;
  logic        out_valid_reg;
  logic [3:0]  rd_reg, rs_reg, rt_reg, offset_reg;
  logic [6:0]  ctrl_reg;
  logic [2:0]  cond_reg;
  logic [8:0]  imm_reg;
  logic [11:0] call_reg;
  logic [15:0] stall_cnt_reg;

  // Decoded view of the offered instruction
  logic [3:0]  rd_next, rs_next, rt_next, offset_next;
  logic [6:0]  ctrl_next;
  logic [2:0]  cond_next;
  logic [8:0]  imm_next;
  logic [11:0] call_next;
  logic        rs_used, rt_used;   // which source fields are real register reads

  logic hazard;
  logic accept;

  always_comb begin
    rd_next     = 4'h0;
    rs_next     = 4'h0;
    rt_next     = 4'h0;
    offset_next = 4'h0;
    ctrl_next   = 7'h00;
    cond_next   = 3'h0;
    imm_next    = 9'h000;
    call_next   = 12'h000;
    rs_used     = 1'b0;
    rt_used     = 1'b0;
    case (instr[15:12])
      4'b1000: begin                      // LW
        rd_next     = instr[11:8];
        rs_next     = instr[7:4];
        offset_next = instr[3:0];
        ctrl_next   = 7'h03;
        rs_used     = 1'b1;
      end
      4'b1001: begin                      // SW
        rt_next     = instr[11:8];
        rs_next     = instr[7:4];
        offset_next = instr[3:0];
        ctrl_next   = 7'h04;
        rs_used     = 1'b1;
        rt_used     = 1'b1;
      end
      4'b1010, 4'b1011: begin             // LHB / LLB
        rd_next   = instr[11:8];
        rs_next   = instr[11:8];
        imm_next  = {1'b0, instr[7:0]};
        ctrl_next = 7'h01;
        rs_used   = 1'b1;
      end
      4'b1100: begin                      // B
        cond_next = instr[11:9];
        imm_next  = instr[8:0];
        ctrl_next = 7'h40;
      end
      4'b1101: begin                      // CALL
        call_next = instr[11:0];
        rd_next   = LINK_REG;
        ctrl_next = 7'h11;
      end
      4'b1110: begin                      // RET
        rs_next   = instr[7:4];
        ctrl_next = 7'h20;
        rs_used   = 1'b1;
      end
      4'b1111: begin                      // HLT
        ctrl_next = 7'h08;
      end
      default: begin                      // ALU ops 0000-0111
        rd_next   = instr[11:8];
        rs_next   = instr[7:4];
        rt_next   = instr[3:0];
        ctrl_next = 7'h01;
        rs_used   = 1'b1;
        rt_used   = 1'b1;
      end
    endcase
  end

  // Load-use: the held bundle is a load (mem_to_reg is unique to LW) whose
  // destination the offered instruction reads. R0 is treated like any other.
  assign hazard = (HAZARD_EN != 0) && out_valid_reg && ctrl_reg[1] && in_valid &&
                  ((rs_used && (rs_next == rd_reg)) || (rt_used && (rt_next == rd_reg)));

  assign in_ready = (state_reg == RUN) && !flush && !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      out_valid_reg <= 1'b0;
      rd_reg        <= 4'h0;
      rs_reg        <= 4'h0;
      rt_reg        <= 4'h0;
      offset_reg    <= 4'h0;
      ctrl_reg      <= 7'h00;
      cond_reg      <= 3'h0;
      imm_reg       <= 9'h000;
      call_reg      <= 12'h000;
      stall_cnt_reg <= 16'h0000;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
      if (state_reg == BUBBLE)
        state_reg <= RUN;
      else if (state_reg == HALTED && HALT_STICKY == 0)
        state_reg <= RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (accept) begin
            out_valid_reg <= 1'b1;
            rd_reg        <= rd_next;
            rs_reg        <= rs_next;
            rt_reg        <= rt_next;
            offset_reg    <= offset_next;
            ctrl_reg      <= ctrl_next;
            cond_reg      <= cond_next;
            imm_reg       <= imm_next;
            call_reg      <= call_next;
            if (ctrl_next[3])
              state_reg <= HALTED;
          end else if (hazard && out_ready) begin
            // Load leaves; the dependent instruction waits out one bubble.
            out_valid_reg <= 1'b0;
            state_reg     <= BUBBLE;
            if (stall_cnt_reg != 16'hFFFF)
              stall_cnt_reg <= stall_cnt_reg + 16'd1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        BUBBLE: begin
          state_reg <= RUN;
          if (out_ready)
            out_valid_reg <= 1'b0;
        end
        HALTED: begin
          if (out_ready)
            out_valid_reg <= 1'b0;
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign rd        = rd_reg;
  assign rs        = rs_reg;
  assign rt        = rt_reg;
  assign ctrl      = ctrl_reg;
  assign cond      = cond_reg;
  assign imm       = imm_reg;
  assign call      = call_reg;
  assign offset    = offset_reg;
  assign halted    = (state_reg == HALTED);
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a default instance (a) and one with HAZARD_EN=0,
// HALT_STICKY=0 (b) share all inputs.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] instr = 16'h0000;

  logic        in_ready_a, out_valid_a, halted_a;
  logic [3:0]  rd_a, rs_a, rt_a, offset_a;
  logic [6:0]  ctrl_a;
  logic [2:0]  cond_a;
  logic [8:0]  imm_a;
  logic [11:0] call_a;
  logic [15:0] stall_a;

  logic        in_ready_b, out_valid_b, halted_b;
  logic [3:0]  rd_b, rs_b, rt_b, offset_b;
  logic [6:0]  ctrl_b;
  logic [2:0]  cond_b;
  logic [8:0]  imm_b;
  logic [11:0] call_b;
  logic [15:0] stall_b;

  decode_stage dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .flush(flush), .out_valid(out_valid_a), .out_ready(out_ready),
    .rd(rd_a), .rs(rs_a), .rt(rt_a), .ctrl(ctrl_a), .cond(cond_a), .imm(imm_a),
    .call(call_a), .offset(offset_a), .halted(halted_a), .stall_cnt(stall_a)
  );

  decode_stage #(.HAZARD_EN(0), .HALT_STICKY(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
    .rd(rd_b), .rs(rs_b), .rt(rt_b), .ctrl(ctrl_b), .cond(cond_b), .imm(imm_b),
    .call(call_b), .offset(offset_b), .halted(halted_b), .stall_cnt(stall_b)
  );

  always #5 clk = ~clk;

  logic [46:0] bundle_a, bundle_b;
  assign bundle_a = {rd_a, rs_a, rt_a, ctrl_a, cond_a, imm_a, call_a, offset_a};
  assign bundle_b = {rd_b, rs_b, rt_b, ctrl_b, cond_b, imm_b, call_b, offset_b};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  rd, rs, rt;
    logic [6:0]  ctrl;
    logic [2:0]  cond;
    logic [8:0]  imm;
    logic [11:0] call;
    logic [3:0]  offset;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [46:0] exp_b;

    vecs[0]  = '{16'h0123, 4'h1, 4'h2, 4'h3, 7'h01, 3'h0, 9'h000, 12'h000, 4'h0};
    vecs[1]  = '{16'h7ABC, 4'hA, 4'hB, 4'hC, 7'h01, 3'h0, 9'h000, 12'h000, 4'h0};
    vecs[2]  = '{16'h8534, 4'h5, 4'h3, 4'h0, 7'h03, 3'h0, 9'h000, 12'h000, 4'h4};
    vecs[3]  = '{16'h9A34, 4'h0, 4'h3, 4'hA, 7'h04, 3'h0, 9'h000, 12'h000, 4'h4};
    vecs[4]  = '{16'hA7C3, 4'h7, 4'h7, 4'h0, 7'h01, 3'h0, 9'h0C3, 12'h000, 4'h0};
    vecs[5]  = '{16'hB2FF, 4'h2, 4'h2, 4'h0, 7'h01, 3'h0, 9'h0FF, 12'h000, 4'h0};
    vecs[6]  = '{16'hCBFF, 4'h0, 4'h0, 4'h0, 7'h40, 3'h5, 9'h1FF, 12'h000, 4'h0};
    vecs[7]  = '{16'hD0A5, 4'hF, 4'h0, 4'h0, 7'h11, 3'h0, 9'h000, 12'h0A5, 4'h0};
    vecs[8]  = '{16'hE3C9, 4'h0, 4'hC, 4'h0, 7'h20, 3'h0, 9'h000, 12'h000, 4'h0};
    vecs[9]  = '{16'h4000, 4'h0, 4'h0, 4'h0, 7'h01, 3'h0, 9'h000, 12'h000, 4'h0};
    vecs[10] = '{16'hF123, 4'h0, 4'h0, 4'h0, 7'h08, 3'h0, 9'h000, 12'h000, 4'h0};

    // ---------------- reset state ----------------
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid_a), 64'd0);
    check("rst_halted", 64'(halted_a), 64'd0);
    check("rst_stall_cnt", 64'(stall_a), 64'd0);
    check("rst_bundle", 64'(bundle_a), 64'd0);
    check("rst_in_ready", 64'(in_ready_a), 64'd1);
    rst_n = 1'b1;

    // ---------------- table-driven decode ----------------
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      instr = vecs[i].instr;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      exp_b = {vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].ctrl, vecs[i].cond,
               vecs[i].imm, vecs[i].call, vecs[i].offset};
      $display("vec %0d instr %h bundle %h expect %h", i, vecs[i].instr, bundle_a, exp_b);
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid_a), 64'd1);
      check($sformatf("vec%0d_bundle", i), 64'(bundle_a), 64'(exp_b));
    end
    check("hlt_vec_halted", 64'(halted_a), 64'd1);

    // ---------------- load-use hazard ----------------
    do_reset();
    instr = 16'h8534;
    in_valid = 1'b1;
    @(negedge clk);                      // LW held
    instr = 16'h0651;                    // reads r5
    #1;
    $display("hazard: LW held rd=%h, ADD offered, in_ready a=%b b=%b", rd_a, in_ready_a, in_ready_b);
    check("haz_lw_valid", 64'(out_valid_a), 64'd1);
    check("haz_lw_ctrl", 64'(ctrl_a), 64'h03);
    check("haz_in_ready_a", 64'(in_ready_a), 64'd0);
    check("haz_in_ready_b", 64'(in_ready_b), 64'd1);
    @(negedge clk);                      // bubble cycle in a, ADD out in b
    $display("bubble: out_valid a=%b stall a=%0d, b rd=%h stall=%0d", out_valid_a, stall_a, rd_b, stall_b);
    check("bub_out_valid", 64'(out_valid_a), 64'd0);
    check("bub_in_ready", 64'(in_ready_a), 64'd0);
    check("bub_stall_cnt", 64'(stall_a), 64'd1);
    check("nohaz_b_valid", 64'(out_valid_b), 64'd1);
    check("nohaz_b_bundle", 64'(bundle_b), 64'({4'h6, 4'h5, 4'h1, 7'h01, 28'h0}));
    check("nohaz_b_stall", 64'(stall_b), 64'd0);
    @(negedge clk);                      // back in RUN, ADD being accepted
    check("post_bub_out_valid", 64'(out_valid_a), 64'd0);
    check("post_bub_in_ready", 64'(in_ready_a), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    $display("dependent ADD out: rd=%h rs=%h rt=%h", rd_a, rs_a, rt_a);
    check("dep_out_valid", 64'(out_valid_a), 64'd1);
    check("dep_bundle", 64'(bundle_a), 64'({4'h6, 4'h5, 4'h1, 7'h01, 28'h0}));
    check("dep_stall_cnt", 64'(stall_a), 64'd1);

    // ---------------- backpressure ----------------
    do_reset();
    instr = 16'h1456;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    instr = 16'h0222;
    for (int c = 0; c < 3; c++) begin
      $display("stall cycle %0d: bundle %h in_ready %b", c, bundle_a, in_ready_a);
      check($sformatf("bp%0d_valid", c), 64'(out_valid_a), 64'd1);
      check($sformatf("bp%0d_bundle", c), 64'(bundle_a), 64'({4'h4, 4'h5, 4'h6, 7'h01, 28'h0}));
      check($sformatf("bp%0d_in_ready", c), 64'(in_ready_a), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready_a), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    $display("after release: bundle %h", bundle_a);
    check("bp_next_bundle", 64'(bundle_a), 64'({4'h2, 4'h2, 4'h2, 7'h01, 28'h0}));

    // ---------------- halt and flush ----------------
    do_reset();
    instr = 16'hF000;
    in_valid = 1'b1;
    @(negedge clk);
    instr = 16'h0123;
    $display("HLT accepted: halted a=%b b=%b ctrl=%h", halted_a, halted_b, ctrl_a);
    check("hlt_halted_a", 64'(halted_a), 64'd1);
    check("hlt_halted_b", 64'(halted_b), 64'd1);
    check("hlt_delivered", 64'({out_valid_a, ctrl_a}), 64'({1'b1, 7'h08}));
    check("hlt_in_ready", 64'(in_ready_a), 64'd0);
    @(negedge clk);
    check("hlt_no_accept", 64'(out_valid_a), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    $display("after flush: halted a=%b b=%b in_ready b=%b", halted_a, halted_b, in_ready_b);
    check("flush_sticky_a", 64'(halted_a), 64'd1);
    check("flush_sticky_a_ready", 64'(in_ready_a), 64'd0);
    check("flush_nonsticky_b", 64'(halted_b), 64'd0);
    check("flush_nonsticky_b_ready", 64'(in_ready_b), 64'd1);
    in_valid = 1'b0;

    // ---------------- flush priority ----------------
    do_reset();
    instr = 16'h0123;
    in_valid = 1'b1;
    @(negedge clk);
    instr = 16'h0456;
    out_ready = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready_a), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    $display("flush with held bundle: out_valid %b", out_valid_a);
    check("flush_clears_valid", 64'(out_valid_a), 64'd0);

    // ---------------- async reset during bubble ----------------
    do_reset();
    instr = 16'h8534;
    in_valid = 1'b1;
    @(negedge clk);
    instr = 16'h0651;
    @(negedge clk);                      // a is in BUBBLE now
    check("pre_rst_stall", 64'(stall_a), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    $display("reset in bubble: out_valid %b stall %0d in_ready %b", out_valid_a, stall_a, in_ready_a);
    check("rst_bub_valid", 64'(out_valid_a), 64'd0);
    check("rst_bub_stall", 64'(stall_a), 64'd0);
    check("rst_bub_run", 64'(in_ready_a), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter LINK_REG, default 4'hF: register index written by CALL.
REQ-002 Parameter HAZARD_EN, default 1: 1 enables load-use bubble insertion; 0 disables it.
REQ-003 Parameter HALT_STICKY, default 1: 1 means only reset leaves HALTED; 0 means flush also leaves HALTED.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  stage accepts instr this cycle.
REQ-008 instr  input  16  instruction; opcode instr[15:12].
REQ-009 flush  input  1  synchronous kill of held and offered instruction.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  downstream accepts bundle.
REQ-012 rd, rs, rt  output  4 each  register indices.
REQ-013 ctrl  output  7  bit0 we, bit1 mem_to_reg, bit2 mem_write, bit3 halt, bit4 jump, bit5 jreg, bit6 branch.
REQ-014 cond  output  3; imm  output  9; call  output  12; offset  output  4.
REQ-015 halted  output  1  stage in HALTED state.
REQ-016 stall_cnt  output  16  saturating count of bubble cycles.

Function
REQ-017 Decode: opcodes 0000-0111 rd=[11:8], rs=[7:4], rt=[3:0], we=1.
REQ-018 LW 1000: rd=[11:8], rs=[7:4] base, offset=[3:0], rt=0, we=1, mem_to_reg=1; no address arithmetic in this block.
REQ-019 SW 1001: rt=[11:8] data source, rs=[7:4] base, offset=[3:0], rd=0, mem_write=1, we=0.
REQ-020 LHB 1010 / LLB 1011: rd=rs=[11:8], imm={1'b0,[7:0]}, rt=0, we=1.
REQ-021 B 1100: cond=[11:9], imm=[8:0], branch=1, we=0, rd=rs=rt=0.
REQ-022 CALL 1101: call=[11:0], rd=LINK_REG, jump=1, we=1.
REQ-023 RET 1110: rs=[7:4], jreg=1, we=0.
REQ-024 HLT 1111: halt=1, all other ctrl bits 0.
REQ-025 Every field not listed for an opcode SHALL be driven 0; no output is left unassigned for any opcode.
REQ-026 Outputs registered; latency 1 cycle from accept (in_valid&in_ready) to out_valid.
REQ-027 in_ready = state RUN & !flush & !hazard & (!out_valid | out_ready).
REQ-028 Held bundle SHALL remain stable while out_valid & !out_ready.
REQ-029 States RUN, BUBBLE, HALTED; reset enters RUN.
REQ-030 Hazard (HAZARD_EN=1): held bundle is LW with rd=R, in_valid=1, offered instr reads R (rs or rt per REQ-017..023); R0 not exempt.
REQ-031 Hazard with out_ready=1: held LW leaves, out_valid drops to 0 next cycle, state RUN->BUBBLE, instr not accepted, stall_cnt +1.
REQ-032 BUBBLE->RUN after exactly one cycle; the dependent instr is accepted that cycle if still offered.
REQ-033 HLT accepted: state->HALTED next cycle; halted=1; in_ready=0; HLT bundle still delivered downstream.
REQ-034 Flush: out_valid cleared next cycle, offered instr not accepted, BUBBLE->RUN; HALTED->RUN only when HALT_STICKY=0.
REQ-035 Flush takes priority over accept, hazard and out_ready in the same cycle; stall_cnt unaffected by flush.
REQ-036 stall_cnt saturates at 16'hFFFF, never wraps.

Reset
REQ-037 rst_n=0 SHALL immediately force state RUN, out_valid=0, halted=0, stall_cnt=0, all field/ctrl outputs 0, regardless of clock.
REQ-038 Reset mid-stall or mid-handshake SHALL discard held bundle; first accept allowed on first rising edge after rst_n=1.

Verification
REQ-039 ADD 16'h0123, out_ready=1 -> next cycle out_valid=1, rd=1, rs=2, rt=3, ctrl=7'h01.
REQ-040 LW 16'h8534 then ADD 16'h0651 -> LW out, one cycle out_valid=0, ADD out next; stall_cnt=1; with HAZARD_EN=0 no bubble, stall_cnt=0.
REQ-041 CALL 16'hD0A5 -> call=12'h0A5, rd=4'hF, ctrl=7'h11; SW 16'h9A34 -> rt=A, rs=3, offset=4, ctrl=7'h04.
REQ-042 out_ready=0 for 3 cycles holding 16'h1456 -> outputs stable, in_ready=0; release -> accept resumes.
REQ-043 HLT 16'hF000 then flush -> HALT_STICKY=1 halted stays 1; HALT_STICKY=0 halted=0, in_ready=1.
REQ-044 rst_n low during BUBBLE -> out_valid=0, stall_cnt=0, state RUN without clock edge.
